mac_vector_sequencer: RTL

//  Parametrised load/compute sequencer for the FP MAC datapath. Captures two operand vectors
//  (A, B) of runtime length 1..DEPTH from a valid/ready word stream into internal buffers.

---
 rtl/mac_vector_sequencer_pkg.sv | 21 ++
 rtl/mac_seq_opbuf.sv | 24 ++
 rtl/mac_vector_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_vector_sequencer_pkg.sv
// Shared definitions for the MAC vector sequencer: state codes, status layout
// and the vector-length decode helper.
package mac_vector_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // A requested length of 0 or anything beyond the buffer depth means "full depth".
  function automatic int eff_len(input int raw, input int depth);
    return (raw == 0 || raw > depth) ? depth : raw;
  endfunction

endpackage

// File: rtl/mac_seq_opbuf.sv
// Operand buffer: DEPTH x DATA_W register file with one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset.
module mac_seq_opbuf #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_vector_sequencer.sv
// Load/compute sequencer for the FP MAC datapath: captures A and B vectors,
// streams them into the MAC beat by beat and returns the accumulated result.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | waiting for start (new load) or rerun (reuse buffers)
//  LOAD_A   | accepting len words into buffer A
//  LOAD_B   | accepting len words into buffer B
//  RUN      | first cycle clears the MAC, then one beat per advance
//  DRAIN    | waiting out the MAC latency after the last beat
//  DONE     | result held until result_ready
module mac_vector_sequencer
  import mac_vector_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int MAC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      rerun,
  input  logic                      abort,
  input  logic [ADDR_W:0]           vec_len,
  input  logic                      auto_run,
  input  logic                      step,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      mac_clr,
  output logic                      mac_en,
  output logic [DATA_W-1:0]         mac_a,
  output logic [DATA_W-1:0]         mac_b,
  input  logic [ACC_W-1:0]          mac_result,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [ACC_W-1:0]          result_data,
  output logic                      busy,
  output logic [STATE_W+ADDR_W-1:0] status
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(MAC_LAT + 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [LEN_W-1:0]  len, len_d;
  logic [CNT_W-1:0]  drain_cnt, drain_cnt_d;
  logic              step_q;
  logic              mac_clr_d, mac_en_d, result_valid_d;
  logic [DATA_W-1:0] mac_a_d, mac_b_d;
  logic [ACC_W-1:0]  result_data_d;
  logic              we_a, we_b;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              accept, last_idx, advance;

  mac_seq_opbuf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_a (
    .clk   (clk),
    .we    (we_a),
    .waddr (idx),
    .wdata (in_data),
    .raddr (idx),
    .rdata (rd_a)
  );

  mac_seq_opbuf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_b (
    .clk   (clk),
    .we    (we_b),
    .waddr (idx),
    .wdata (in_data),
    .raddr (idx),
    .rdata (rd_b)
  );

  assign in_ready = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign busy     = (state != ST_IDLE);
  assign status   = {state, idx};
  assign accept   = in_valid & in_ready;
  assign last_idx = ({1'b0, idx} == (len - 1'b1));
  assign advance  = auto_run | (step & ~step_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      len          <= LEN_W'(DEPTH);
      drain_cnt    <= '0;
      step_q       <= 1'b0;
      mac_clr      <= 1'b0;
      mac_en       <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      len          <= len_d;
      drain_cnt    <= drain_cnt_d;
      step_q       <= step;
      mac_clr      <= mac_clr_d;
      mac_en       <= mac_en_d;
      mac_a        <= mac_a_d;
      mac_b        <= mac_b_d;
      result_valid <= result_valid_d;
      result_data  <= result_data_d;
    end
  end

  always_comb begin
    state_d        = state;
    idx_d          = idx;
    len_d          = len;
    drain_cnt_d    = drain_cnt;
    mac_clr_d      = 1'b0;
    mac_en_d       = 1'b0;
    mac_a_d        = mac_a;
    mac_b_d        = mac_b;
    result_valid_d = result_valid;
    result_data_d  = result_data;
    we_a           = 1'b0;
    we_b           = 1'b0;

    case (state)
      ST_IDLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          len_d   = LEN_W'(eff_len(int'(vec_len), DEPTH));
          idx_d   = '0;
          state_d = ST_LOAD_A;
        end else if (rerun) begin
          idx_d     = '0;
          mac_clr_d = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_LOAD_A: begin
        if (accept) begin
          we_a = 1'b1;
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_LOAD_B;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (accept) begin
          we_b = 1'b1;
          if (last_idx) begin
            idx_d     = '0;
            mac_clr_d = 1'b1;
            state_d   = ST_RUN;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      ST_RUN: begin
        // mac_clr is high only in the first RUN cycle, which never carries a beat
        if (!mac_clr && advance) begin
          mac_en_d = 1'b1;
          mac_a_d  = rd_a;
          mac_b_d  = rd_b;
          if (last_idx) begin
            idx_d       = '0;
            drain_cnt_d = CNT_W'(MAC_LAT);
            state_d     = ST_DRAIN;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == CNT_W'(1)) begin
          result_data_d  = mac_result;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; buffers and len survive so rerun can reuse them.
    if (abort && state != ST_IDLE) begin
      state_d        = ST_IDLE;
      idx_d          = '0;
      mac_en_d       = 1'b0;
      mac_clr_d      = 1'b0;
      result_valid_d = 1'b0;
    end
  end

endmodule
